// File: rtl/xil_mm_pkg.sv
// Shared types and constants for the Xillybus mmreq/mmresp register-bus bridge.
package xil_mm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HAVE_ADR = 2'd1,
        ST_BUS      = 2'd2,
        ST_RESP     = 2'd3
    } state_t;

    localparam int          WR_BIT       = 31;
    localparam logic [31:0] TIMEOUT_WORD = 32'hDEADDEAD;
    localparam logic [3:0]  WRACK_TAG    = 4'b1000;

    localparam int ADR_W_DEF      = 28;
    localparam int TIMEOUT_DEF    = 1024;
    localparam int RESP_DEPTH_DEF = 16;

endpackage

// File: rtl/xil_mm_resp_fifo.sv
// Standard (registered-output) response FIFO feeding the mmresp stream.
// flush empties it and blocks pushes/pops while asserted.
module xil_mm_resp_fifo
    import xil_mm_pkg::*;
#(
    parameter int RESP_DEPTH = RESP_DEPTH_DEF
) (
    input  logic        clk_i,
    input  logic        aresetn_i,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] push_dat,
    input  logic        pop,
    output logic [31:0] pop_dat,
    output logic        empty,
    output logic        full
);

    localparam int AW = $clog2(RESP_DEPTH);

    logic [31:0]   mem [RESP_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(RESP_DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // NOTE: storage has no reset; count alone defines which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pop_dat <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                pop_dat <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/xil_mm_bridge.sv
// mmreq word-pair to register-bus bridge with mmresp result stream.
// Build option XIL_MM_WRACK_EN: writes also return an acknowledge word.
module xil_mm_bridge
    import xil_mm_pkg::*;
#(
    parameter int ADR_W      = ADR_W_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int RESP_DEPTH = RESP_DEPTH_DEF
) (
    input  logic             clk_i,
    input  logic             aresetn_i,
    input  logic [31:0]      req_dat_i,
    input  logic             req_wren_i,
    output logic             req_full_o,
    input  logic             req_open_i,
    output logic [31:0]      resp_dat_o,
    input  logic             resp_rden_i,
    output logic             resp_empty_o,
    output logic             resp_eof_o,
    input  logic             resp_open_i,
    output logic             en_o,
    output logic             wr_o,
    input  logic             ack_i,
    output logic [ADR_W-1:0] adr_o,
    input  logic [31:0]      dat_i,
    output logic [31:0]      dat_o,
    output logic [15:0]      timeout_cnt_o
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic          timed_out;
    logic [31:0]   rd_dat;
    logic [31:0]   resp_word;
    logic          need_resp;
    logic          fifo_full;
    logic          push;
    logic          resp_done;
    logic          unused_bits;

    assign unused_bits = ^req_dat_i[WR_BIT-1:ADR_W];
    assign req_full_o  = (state == ST_BUS) || (state == ST_RESP);
    assign resp_eof_o  = 1'b0;

    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    always_comb begin
        resp_word = timed_out ? TIMEOUT_WORD : rd_dat;
`ifdef XIL_MM_WRACK_EN
        need_resp = 1'b1;
        if (wr_o && !timed_out) resp_word = {WRACK_TAG, 28'(adr_o)};
`else
        need_resp = !wr_o;
`endif
    end

    // With the host side closed the word is discarded, so RESP never waits.
    assign push      = (state == ST_RESP) && need_resp && resp_open_i && !fifo_full;
    assign resp_done = !need_resp || !resp_open_i || !fifo_full;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state         <= ST_IDLE;
            en_o          <= 1'b0;
            wr_o          <= 1'b0;
            adr_o         <= '0;
            dat_o         <= '0;
            rd_dat        <= '0;
            timed_out     <= 1'b0;
            tmo_cnt       <= '0;
            timeout_cnt_o <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req_wren_i) begin
                    wr_o  <= req_dat_i[WR_BIT];
                    adr_o <= req_dat_i[ADR_W-1:0];
                    state <= ST_HAVE_ADR;
                end
                ST_HAVE_ADR: begin
                    if (!req_open_i) begin
                        state <= ST_IDLE;
                    end else if (req_wren_i) begin
                        dat_o     <= req_dat_i;
                        en_o      <= 1'b1;
                        tmo_cnt   <= '0;
                        timed_out <= 1'b0;
                        state     <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (ack_i) begin
                        en_o  <= 1'b0;
                        if (!wr_o) rd_dat <= dat_i;
                        state <= ST_RESP;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        en_o      <= 1'b0;
                        timed_out <= 1'b1;
                        if (timeout_cnt_o != 16'hFFFF) timeout_cnt_o <= timeout_cnt_o + 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_RESP: if (resp_done) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    xil_mm_resp_fifo #(.RESP_DEPTH(RESP_DEPTH)) u_resp_fifo (
        .clk_i     (clk_i),
        .aresetn_i (aresetn_i),
        .flush     (!resp_open_i),
        .push      (push),
        .push_dat  (resp_word),
        .pop       (resp_rden_i),
        .pop_dat   (resp_dat_o),
        .empty     (resp_empty_o),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_xil_mm_bridge.sv
// Scoreboard bench for xil_mm_bridge; expected response words are queued at request time.
module tb_xil_mm_bridge;
    import xil_mm_pkg::*;

    localparam int ADR_W = 28;

    logic             clk_i = 1'b0;
    logic             aresetn_i;
    logic [31:0]      req_dat_i;
    logic             req_wren_i;
    logic             req_full_o;
    logic             req_open_i;
    logic [31:0]      resp_dat_o;
    logic             resp_rden_i;
    logic             resp_empty_o;
    logic             resp_eof_o;
    logic             resp_open_i;
    logic             en_o;
    logic             wr_o;
    logic             ack_i;
    logic [ADR_W-1:0] adr_o;
    logic [31:0]      dat_i;
    logic [31:0]      dat_o;
    logic [15:0]      timeout_cnt_o;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    int          en_cycles = 0;
    logic        seen_wr;
    logic [ADR_W-1:0] seen_adr;
    logic [31:0] seen_dat;
    logic        ack_auto;

    xil_mm_bridge dut (
        .clk_i(clk_i), .aresetn_i(aresetn_i),
        .req_dat_i(req_dat_i), .req_wren_i(req_wren_i), .req_full_o(req_full_o),
        .req_open_i(req_open_i), .resp_dat_o(resp_dat_o), .resp_rden_i(resp_rden_i),
        .resp_empty_o(resp_empty_o), .resp_eof_o(resp_eof_o), .resp_open_i(resp_open_i),
        .en_o(en_o), .wr_o(wr_o), .ack_i(ack_i), .adr_o(adr_o), .dat_i(dat_i),
        .dat_o(dat_o), .timeout_cnt_o(timeout_cnt_o)
    );

    assign ack_i = ack_auto & en_o;

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (en_o) begin
            en_cycles++;
            seen_wr  = wr_o;
            seen_adr = adr_o;
            seen_dat = dat_o;
        end
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        tick();
        req_dat_i  = w;
        req_wren_i = 1'b1;
        tick();
        req_wren_i = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int k;
        for (k = 0; k < max && req_full_o; k++) tick();
        checks++;
        if (req_full_o !== 1'b0) begin
            errors++;
            $display("FAIL %s: req_full_o still %b after %0d cycles, required 0", name, req_full_o, max);
        end
    endtask

    task automatic read_resp(input string name);
        logic [31:0] exp;
        int k;
        for (k = 0; k < 200 && resp_empty_o; k++) tick();
        checks++;
        if (resp_empty_o !== 1'b0) begin
            errors++;
            $display("FAIL %s: no response word within 200 cycles, resp_empty_o=%b required 0", name, resp_empty_o);
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected response word, resp_empty_o=%b required 1", name, resp_empty_o);
        end else begin
            resp_rden_i = 1'b1;
            tick();
            resp_rden_i = 1'b0;
            exp = exp_q.pop_front();
            if (resp_dat_o !== exp) begin
                errors++;
                $display("FAIL %s: resp_dat_o=%h required %h", name, resp_dat_o, exp);
            end
        end
    endtask

    task automatic test_reset();
        aresetn_i = 1'b0; req_dat_i = '0; req_wren_i = 1'b0; req_open_i = 1'b1;
        resp_rden_i = 1'b0; resp_open_i = 1'b1; dat_i = '0; ack_auto = 1'b1;
        repeat (3) tick();
        checks++;
        if ({en_o, wr_o, adr_o, dat_o, req_full_o, resp_dat_o, timeout_cnt_o, resp_empty_o, resp_eof_o}
            !== {1'b0, 1'b0, 28'd0, 32'd0, 1'b0, 32'd0, 16'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: en=%b wr=%b adr=%h dat=%h full=%b rdat=%h tcnt=%h empty=%b eof=%b required all 0 except empty=1",
                     en_o, wr_o, adr_o, dat_o, req_full_o, resp_dat_o, timeout_cnt_o, resp_empty_o, resp_eof_o);
        end
        aresetn_i = 1'b1;
        tick();
    endtask

    task automatic test_read();
        dat_i = 32'h12345678;
        en_cycles = 0;
        send_word(32'h00000002);
        send_word(32'h00000000);
        exp_q.push_back(32'h12345678);
        checks++;
        if (en_o !== 1'b1) begin
            errors++; $display("FAIL read_en_latency: en_o=%b required 1", en_o);
        end
        tick();
        checks++;
        if ({en_o, resp_empty_o} !== 2'b01) begin
            errors++; $display("FAIL read_en_drop: en_o=%b resp_empty_o=%b required 0 1", en_o, resp_empty_o);
        end
        tick();
        checks++;
        if (resp_empty_o !== 1'b0) begin
            errors++; $display("FAIL read_resp_latency: resp_empty_o=%b required 0", resp_empty_o);
        end
        checks++;
        if (en_cycles !== 1 || seen_wr !== 1'b0 || seen_adr !== 28'd2) begin
            errors++;
            $display("FAIL read_bus: en cycles=%0d wr=%b adr=%h required 1 0 2", en_cycles, seen_wr, seen_adr);
        end
        read_resp("read_data");
        resp_rden_i = 1'b1;
        tick();
        resp_rden_i = 1'b0;
        checks++;
        if (resp_dat_o !== 32'h12345678 || resp_empty_o !== 1'b1) begin
            errors++;
            $display("FAIL rden_empty_hold: resp_dat_o=%h empty=%b required 12345678 1", resp_dat_o, resp_empty_o);
        end
    endtask

    task automatic test_write();
        en_cycles = 0;
        send_word(32'h80000002);
        send_word(32'hCAFEF00D);
        wait_idle("write_idle", 50);
        checks++;
        if (en_cycles !== 1 || seen_wr !== 1'b1 || seen_adr !== 28'd2 || seen_dat !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL write_bus: en cycles=%0d wr=%b adr=%h dat=%h required 1 1 2 cafef00d",
                     en_cycles, seen_wr, seen_adr, seen_dat);
        end
`ifdef XIL_MM_WRACK_EN
        exp_q.push_back(32'h80000002);
        read_resp("write_ack");
`else
        repeat (4) tick();
        checks++;
        if (resp_empty_o !== 1'b1) begin
            errors++; $display("FAIL write_no_resp: resp_empty_o=%b required 1", resp_empty_o);
        end
`endif
    endtask

    task automatic test_timeout();
        int k;
        ack_auto = 1'b0;
        en_cycles = 0;
        send_word(32'h00000005);
        send_word(32'h00000000);
        exp_q.push_back(32'hDEADDEAD);
        for (k = 0; k < 1100 && en_o; k++) tick();
        checks++;
        if (en_cycles !== 1024) begin
            errors++; $display("FAIL timeout_en_len: en_o high %0d cycles required 1024", en_cycles);
        end
        ack_auto = 1'b1;
        read_resp("timeout_word");
        checks++;
        if (timeout_cnt_o !== 16'd1) begin
            errors++; $display("FAIL timeout_count: timeout_cnt_o=%0d required 1", timeout_cnt_o);
        end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 17; i++) begin
            dat_i = 32'h10000000 + 32'(i * 17);
            send_word(32'(i));
            send_word(32'h00000000);
            exp_q.push_back(32'h10000000 + 32'(i * 17));
            if (i < 16) wait_idle("fifo_fill", 50);
        end
        repeat (5) tick();
        checks++;
        if ({req_full_o, en_o} !== 2'b10) begin
            errors++; $display("FAIL fifo_stall: req_full_o=%b en_o=%b required 1 0", req_full_o, en_o);
        end
        read_resp("fifo_first");
        repeat (2) tick();
        checks++;
        if (req_full_o !== 1'b0) begin
            errors++; $display("FAIL fifo_release: req_full_o=%b required 0", req_full_o);
        end
        for (int i = 1; i < 17; i++) read_resp("fifo_order");
        checks++;
        if (resp_empty_o !== 1'b1) begin
            errors++; $display("FAIL fifo_drained: resp_empty_o=%b required 1", resp_empty_o);
        end
    endtask

    task automatic test_open_drop();
        en_cycles = 0;
        send_word(32'h00000007);
        req_open_i = 1'b0;
        tick();
        req_open_i = 1'b1;
        dat_i = 32'hA5A55A5A;
        send_word(32'h00000001);
        send_word(32'h00000000);
        exp_q.push_back(32'hA5A55A5A);
        wait_idle("open_idle", 50);
        checks++;
        if (en_cycles !== 1 || seen_wr !== 1'b0 || seen_adr !== 28'd1) begin
            errors++;
            $display("FAIL open_drop_bus: en cycles=%0d wr=%b adr=%h required 1 0 1", en_cycles, seen_wr, seen_adr);
        end
        read_resp("open_drop_data");
    endtask

    task automatic test_resp_closed();
        resp_open_i = 1'b0;
        dat_i = 32'h0BADF00D;
        send_word(32'h00000004);
        send_word(32'h00000000);
        wait_idle("closed_no_stall", 20);
        resp_open_i = 1'b1;
        tick();
        checks++;
        if (resp_empty_o !== 1'b1) begin
            errors++; $display("FAIL closed_discard: resp_empty_o=%b required 1", resp_empty_o);
        end
    endtask

    task automatic test_reset_mid_bus();
        ack_auto = 1'b0;
        send_word(32'h00000003);
        send_word(32'h00000000);
        repeat (3) tick();
        checks++;
        if (en_o !== 1'b1) begin
            errors++; $display("FAIL midbus_precond: en_o=%b required 1", en_o);
        end
        aresetn_i = 1'b0;
        #1;
        checks++;
        if ({en_o, resp_empty_o, req_full_o, timeout_cnt_o} !== {1'b0, 1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL midbus_reset: en=%b empty=%b full=%b tcnt=%0d required 0 1 0 0",
                     en_o, resp_empty_o, req_full_o, timeout_cnt_o);
        end
        en_cycles = 0;
        tick();
        aresetn_i = 1'b1;
        ack_auto = 1'b1;
        repeat (10) tick();
        checks++;
        if (resp_empty_o !== 1'b1 || en_cycles !== 0) begin
            errors++;
            $display("FAIL midbus_no_resp: resp_empty_o=%b en cycles=%0d required 1 0", resp_empty_o, en_cycles);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_fifo_full();
        test_open_drop();
        test_resp_closed();
        test_reset_mid_bus();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_left: %0d words outstanding required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
